// File: rtl/dp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_pkg
// Description : Shared types, read-latency constants and byte-parity helper
//               for the parametrised dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dp_ram_state_e;

  localparam int c_RD_LAT_ONE = 1;
  localparam int c_RD_LAT_TWO = 2;

  // Even parity: the stored bit makes the 9-bit group have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_ram_param_if.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_param_if
// Description : Write/read bus of the dual-port RAM; parity signals exist
//               only when DPRAM_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface dp_ram_param_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_done;
`ifdef DPRAM_PARITY_EN
  logic                  rd_perr;
  logic                  wr_perr_inj;
`endif

  modport master (
`ifdef DPRAM_PARITY_EN
    output wr_perr_inj,
    input  rd_perr,
`endif
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_done
  );

  modport slave (
`ifdef DPRAM_PARITY_EN
    input  wr_perr_inj,
    output rd_perr,
`endif
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_done
  );

endinterface
`default_nettype wire

// File: rtl/dp_ram_param_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_init_ctrl
// Description : Post-reset clearing sequencer: walks addresses 0..DEPTH-1,
//               then parks in ST_READY with init_done registered high.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_init_ctrl
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  wire                   clk,
  input  wire                   rst,
  output logic                  init_active_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o,
  output logic                  init_done_o
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  dp_ram_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == c_LAST_ADDR) begin
          state_d = ST_READY;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    init_active_o = (state_q == ST_INIT);
    init_addr_o   = cnt_q;
    init_done_o   = done_q;
  end

endmodule
`default_nettype wire

// File: rtl/dp_ram_param.sv
`default_nettype none
// ============================================================================
// Module      : dp_ram_param
// Description : Simple dual-port RAM with byte enables, 1/2-cycle read latency,
//               optional write bypass; optional parity via DPRAM_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  parameter int WR_BYPASS  = 1
) (
  input  wire           clk,
  input  wire           rst,
  dp_ram_param_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  init_active;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_done;

  dp_ram_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_init_ctrl (
    .clk           (clk),
    .rst           (rst),
    .init_active_o (init_active),
    .init_addr_o   (init_addr),
    .init_done_o   (init_done)
  );

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_in_range, rd_in_range, rd_accept;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_in_range = {1'b0, bus.wr_addr} < c_DEPTH_EXT;
  assign rd_in_range = {1'b0, bus.rd_addr} < c_DEPTH_EXT;
  assign rd_accept   = !init_active && bus.rd_en;

  always_ff @(posedge clk) begin
    if (init_active) begin
      mem_q[init_addr] <= '0;
    end else if (bus.wr_en && wr_in_range) begin
      for (int b = 0; b < NB; b++)
        if (bus.wr_be[b]) mem_q[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rd_par;
  logic          rd_perr_calc;

  always_ff @(posedge clk) begin
    if (init_active) begin
      par_q[init_addr] <= '0;
    end else if (bus.wr_en && wr_in_range) begin
      for (int b = 0; b < NB; b++)
        if (bus.wr_be[b])
          par_q[bus.wr_addr][b] <= byte_parity(bus.wr_data[8*b +: 8]) ^ bus.wr_perr_inj;
    end
  end
`endif

  // Out-of-range reads yield zero; a same-address write can be forwarded byte-wise.
  always_comb begin
    rd_word = '0;
`ifdef DPRAM_PARITY_EN
    rd_par       = '0;
    rd_perr_calc = 1'b0;
`endif
    if (rd_in_range) begin
      rd_word = mem_q[bus.rd_addr];
`ifdef DPRAM_PARITY_EN
      rd_par = par_q[bus.rd_addr];
`endif
      if ((WR_BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_be[b]) begin
            rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
`ifdef DPRAM_PARITY_EN
            rd_par[b] = byte_parity(bus.wr_data[8*b +: 8]) ^ bus.wr_perr_inj;
`endif
          end
        end
      end
    end
`ifdef DPRAM_PARITY_EN
    for (int b = 0; b < NB; b++)
      rd_perr_calc = rd_perr_calc | (byte_parity(rd_word[8*b +: 8]) ^ rd_par[b]);
`endif
  end

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
`ifdef DPRAM_PARITY_EN
  logic                  s_perr;
`endif

  generate
    if (RD_LATENCY == c_RD_LAT_TWO) begin : g_lat2
      logic [DATA_WIDTH-1:0] p_data_q;
      logic                  p_valid_q;
`ifdef DPRAM_PARITY_EN
      logic                  p_perr_q;
`endif
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_data_q  <= '0;
          p_valid_q <= 1'b0;
`ifdef DPRAM_PARITY_EN
          p_perr_q  <= 1'b0;
`endif
        end else begin
          p_valid_q <= rd_accept;
          if (rd_accept) p_data_q <= rd_word;
`ifdef DPRAM_PARITY_EN
          if (rd_accept) p_perr_q <= rd_perr_calc;
`endif
        end
      end
      assign s_data  = p_data_q;
      assign s_valid = p_valid_q;
`ifdef DPRAM_PARITY_EN
      assign s_perr  = p_perr_q;
`endif
    end else begin : g_lat1
      assign s_data  = rd_word;
      assign s_valid = rd_accept;
`ifdef DPRAM_PARITY_EN
      assign s_perr  = rd_perr_calc;
`endif
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
`ifdef DPRAM_PARITY_EN
  logic                  rd_perr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef DPRAM_PARITY_EN
      rd_perr_q  <= 1'b0;
`endif
    end else begin
      rd_valid_q <= s_valid;
      if (s_valid) rd_data_q <= s_data;
`ifdef DPRAM_PARITY_EN
      rd_perr_q  <= s_valid & s_perr;
`endif
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_done = init_done;
`ifdef DPRAM_PARITY_EN
  assign bus.rd_perr   = rd_perr_q;
`endif

endmodule
`default_nettype wire
